sim_watchdog_ctrl: RTL and testbench

//   Multi-core commit watchdog controller for the simulation top. Tracks per-core

---
 rtl/sim_watchdog_ctrl.sv | 158 +++++++++++++++
 tb/tb_sim_watchdog_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sim_watchdog_ctrl.sv
// Multi-core commit watchdog: per-core stuck counters, round-robin trip
// reporting over a valid/ready channel and a sticky finish request.
module sim_watchdog_ctrl #(
  parameter int               NUM_CORES     = 2,
  parameter int               CNT_W         = 64,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(15000)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] commit_valid,
  input  logic                 cfg_valid,
  input  logic [CNT_W-1:0]     cfg_limit,
  input  logic                 cfg_enable,
  output logic [NUM_CORES-1:0] core_tripped,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [3:0]           rpt_core_id,
  output logic [CNT_W-1:0]     rpt_limit,
  output logic [CNT_W-1:0]     rpt_stamp,
  output logic                 finish_req
);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    RUNNING,
    TRIPPED,
    REPORTED
  } core_st_t;

  core_st_t         st         [NUM_CORES];
  logic [CNT_W-1:0] cnt        [NUM_CORES];
  logic [CNT_W-1:0] trip_limit [NUM_CORES];
  logic [CNT_W-1:0] trip_stamp [NUM_CORES];

  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] stamp;
  logic             enable;
  logic [3:0]       rr_ptr;

  logic             hs;
  logic             disarm;
  logic             gnt_found;
  logic [3:0]       gnt_id;
  logic [CNT_W-1:0] gnt_limit;
  logic [CNT_W-1:0] gnt_stamp;

  assign hs     = rpt_valid && rpt_ready;
  assign disarm = cfg_valid && !cfg_enable;

  // Tripped view: a core stays flagged once it has tripped, reported or not.
  always_comb begin
    core_tripped = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_tripped[i] = (st[i] == TRIPPED) || (st[i] == REPORTED);
    end
  end

  // Round-robin pick: first TRIPPED core at or after the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_limit = '0;
    gnt_stamp = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!gnt_found && st[i] == TRIPPED &&
            i == (int'(rr_ptr) + k) % NUM_CORES) begin
          gnt_found = 1'b1;
          gnt_id    = 4'(i);
          gnt_limit = trip_limit[i];
          gnt_stamp = trip_stamp[i];
        end
      end
    end
  end

  // Free-running stamp and runtime configuration registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stamp  <= '0;
      limit  <= DEFAULT_LIMIT;
      enable <= 1'b1;
    end else begin
      stamp <= stamp + 1'b1;
      if (cfg_valid) begin
        limit  <= cfg_limit;
        enable <= cfg_enable;
      end
    end
  end

  // Per-core liveness FSMs; a completed handshake retires the granted core.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        st[i]         <= WAIT_FIRST;
        cnt[i]        <= DEFAULT_LIMIT;
        trip_limit[i] <= '0;
        trip_stamp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (st[i] == REPORTED) begin
          st[i] <= REPORTED;
        end else if (hs && rpt_core_id == 4'(i) && st[i] == TRIPPED) begin
          st[i] <= REPORTED;
        end else if (disarm) begin
          st[i]  <= WAIT_FIRST;
          cnt[i] <= limit;
        end else begin
          unique case (st[i])
            WAIT_FIRST: begin
              cnt[i] <= limit;
              if (commit_valid[i] && enable) st[i] <= RUNNING;
            end
            RUNNING: begin
              if (commit_valid[i]) begin
                cnt[i] <= limit;
              end else if (cnt[i] == '0) begin
                st[i]         <= TRIPPED;
                trip_limit[i] <= limit;
                trip_stamp[i] <= stamp;
              end else begin
                cnt[i] <= cnt[i] - 1'b1;
              end
            end
            default: st[i] <= st[i];
          endcase
        end
      end
    end
  end

  // Report channel: hold one grant until accepted, then a one-cycle gap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_valid   <= 1'b0;
      rpt_core_id <= '0;
      rpt_limit   <= '0;
      rpt_stamp   <= '0;
      rr_ptr      <= '0;
      finish_req  <= 1'b0;
    end else if (hs) begin
      rpt_valid  <= 1'b0;
      finish_req <= 1'b1;
      if (rpt_core_id == 4'(NUM_CORES - 1)) rr_ptr <= '0;
      else rr_ptr <= rpt_core_id + 1'b1;
    end else if (disarm) begin
      rpt_valid <= 1'b0;
    end else if (!rpt_valid && gnt_found) begin
      rpt_valid   <= 1'b1;
      rpt_core_id <= gnt_id;
      rpt_limit   <= gnt_limit;
      rpt_stamp   <= gnt_stamp;
    end
  end

endmodule

// File: tb/tb_sim_watchdog_ctrl.sv
// Bench for sim_watchdog_ctrl: vector table plus directed
// multi-cycle sequences for trip timing, arbitration and reset.
module tb_sim_watchdog_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  commit_valid = '0;
  logic        cfg_valid = 1'b0;
  logic [63:0] cfg_limit = '0;
  logic        cfg_enable = 1'b1;
  logic [1:0]  core_tripped;
  logic        rpt_valid;
  logic        rpt_ready = 1'b0;
  logic [3:0]  rpt_core_id;
  logic [63:0] rpt_limit;
  logic [63:0] rpt_stamp;
  logic        finish_req;

  int n_tests = 0;
  int n_fail  = 0;

  sim_watchdog_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .cfg_valid    (cfg_valid),
    .cfg_limit    (cfg_limit),
    .cfg_enable   (cfg_enable),
    .core_tripped (core_tripped),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_core_id  (rpt_core_id),
    .rpt_limit    (rpt_limit),
    .rpt_stamp    (rpt_stamp),
    .finish_req   (finish_req)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  commit;
    logic        cfgv;
    logic [63:0] lim;
    logic        en;
    logic        rdy;
    logic [1:0]  e_trip;
    logic        e_rv;
    logic [3:0]  e_id;
    logic [63:0] e_lim;
    logic [63:0] e_stamp;
    logic        e_fin;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic cv,
                      input logic [63:0] l, input logic e,
                      input logic r);
    commit_valid = c;
    cfg_valid    = cv;
    cfg_limit    = l;
    cfg_enable   = e;
    rpt_ready    = r;
    @(posedge clock);
    #1;
    commit_valid = '0;
    cfg_valid    = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    commit_valid = '0;
    cfg_valid    = 1'b0;
    cfg_enable   = 1'b1;
    rpt_ready    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 64'd0, 1'b1, r);
  endtask

  initial begin
    vec[0] = '{2'b00, 1'b1, 64'd2, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0};
    vec[1] = '{2'b11, 1'b0, 64'd0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0};
    vec[2] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0};
    vec[3] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0};
    vec[4] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b0, 2'b11, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0};
    vec[5] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b0, 2'b11, 1'b1, 4'd0, 64'd2, 64'd4, 1'b0};
    vec[6] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b1, 2'b11, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1};
    vec[7] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b1, 2'b11, 1'b1, 4'd1, 64'd2, 64'd4, 1'b1};
    vec[8] = '{2'b00, 1'b0, 64'd0, 1'b1, 1'b1, 2'b11, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1};
    vec[9] = '{2'b11, 1'b0, 64'd0, 1'b1, 1'b0, 2'b11, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1};

    // Default limit trip timing, lone core, no commits on core1.
    do_reset();
    check("rst_tripped", core_tripped, 0);
    check("rst_rpt_valid", rpt_valid, 0);
    check("rst_finish", finish_req, 0);
    check("rst_id", rpt_core_id, 0);
    for (int c = 1; c <= 15012; c++) begin
      step((c == 10) ? 2'b01 : 2'b00, 1'b0, 64'd0, 1'b1, 1'b0);
      if (c == 15010) check("t1_pre_trip", core_tripped, 0);
      if (c == 15011) begin
        check("t1_trip", core_tripped, 2'b01);
        check("t1_rv_latency", rpt_valid, 0);
      end
      if (c == 15012) begin
        check("t1_rv", rpt_valid, 1);
        check("t1_id", rpt_core_id, 0);
        check("t1_limit", rpt_limit, 15000);
        check("t1_stamp", rpt_stamp, 15010);
        check("t1_fin_pre", finish_req, 0);
      end
    end
    step(2'b00, 1'b0, 64'd0, 1'b1, 1'b1);
    check("t1_fin", finish_req, 1);
    check("t1_rv_drop", rpt_valid, 0);
    idle(3, 1'b0);
    check("t4_core1_idle", core_tripped, 2'b01);
    check("t4_no_report", rpt_valid, 0);

    // Vector table: limit 2, both cores trip together.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vec[i].commit, vec[i].cfgv, vec[i].lim, vec[i].en, vec[i].rdy);
      check($sformatf("vec%0d_trip", i), core_tripped, vec[i].e_trip);
      check($sformatf("vec%0d_rv", i), rpt_valid, vec[i].e_rv);
      check($sformatf("vec%0d_fin", i), finish_req, vec[i].e_fin);
      if (vec[i].e_rv) begin
        check($sformatf("vec%0d_id", i), rpt_core_id, vec[i].e_id);
        check($sformatf("vec%0d_lim", i), rpt_limit, vec[i].e_lim);
        check($sformatf("vec%0d_stamp", i), rpt_stamp, vec[i].e_stamp);
      end
    end

    // Limit 4, core1 commits every 4 cycles then stops at cycle 100.
    do_reset();
    begin
      logic seen;
      seen = 1'b0;
      step(2'b00, 1'b1, 64'd4, 1'b1, 1'b0);
      for (int c = 2; c <= 105; c++) begin
        step((c % 4 == 0 && c <= 100) ? 2'b10 : 2'b00,
             1'b0, 64'd0, 1'b1, 1'b0);
        if (c <= 104 && core_tripped != 2'b00) seen = 1'b1;
        if (c == 104) check("t2_no_early_trip", seen, 0);
        if (c == 105) check("t2_trip_105", core_tripped, 2'b10);
      end
      step(2'b00, 1'b0, 64'd0, 1'b1, 1'b0);
      check("t2_id", rpt_core_id, 1);
      check("t2_limit", rpt_limit, 4);
    end

    // Same-edge trips with a stalled consumer.
    do_reset();
    step(2'b00, 1'b1, 64'd3, 1'b1, 1'b0);
    step(2'b11, 1'b0, 64'd0, 1'b1, 1'b0);
    idle(4, 1'b0);
    check("t3_trip", core_tripped, 2'b11);
    check("t3_rv_latency", rpt_valid, 0);
    idle(1, 1'b0);
    check("t3_rv", rpt_valid, 1);
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b0);
      check($sformatf("t3_hold_id%0d", i), rpt_core_id, 0);
      check($sformatf("t3_hold_rv%0d", i), rpt_valid, 1);
    end
    check("t3_hold_stamp", rpt_stamp, 5);
    check("t3_fin_pre", finish_req, 0);
    idle(1, 1'b1);
    check("t3_gap", rpt_valid, 0);
    check("t3_fin", finish_req, 1);
    idle(1, 1'b0);
    check("t3_rv2", rpt_valid, 1);
    check("t3_id2", rpt_core_id, 1);
    check("t3_stamp2", rpt_stamp, 5);

    // Disarm mid-count, re-arm with same-edge commit, then real trip.
    do_reset();
    step(2'b00, 1'b1, 64'd5, 1'b1, 1'b0);
    step(2'b01, 1'b0, 64'd0, 1'b1, 1'b0);
    idle(3, 1'b0);
    step(2'b00, 1'b1, 64'd5, 1'b0, 1'b0);
    idle(10, 1'b0);
    check("t5_disarmed", core_tripped, 0);
    step(2'b01, 1'b1, 64'd5, 1'b1, 1'b0);
    idle(10, 1'b0);
    check("t5_cfg_wins", core_tripped, 0);
    step(2'b01, 1'b0, 64'd0, 1'b1, 1'b0);
    idle(5, 1'b0);
    check("t5_pre_trip", core_tripped, 0);
    idle(1, 1'b0);
    check("t5_trip", core_tripped, 2'b01);

    // Limit 0 boundary, then async reset with a report pending.
    do_reset();
    step(2'b00, 1'b1, 64'd0, 1'b1, 1'b0);
    step(2'b01, 1'b0, 64'd0, 1'b1, 1'b0);
    idle(1, 1'b0);
    check("t6_l0_trip", core_tripped, 2'b01);
    idle(1, 1'b0);
    check("t6_rv", rpt_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_trip", core_tripped, 0);
    check("t6_async_rv", rpt_valid, 0);
    check("t6_async_fin", finish_req, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(5, 1'b1);
    check("t6_post_trip", core_tripped, 0);
    check("t6_post_rv", rpt_valid, 0);
    check("t6_post_fin", finish_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
